// File: rtl/proc_pkg.sv
// Shared processor definitions: stack instruction prefix and stack sub-op encoding.
package proc_pkg;

   localparam logic [6:0] STACK_PREFIX = 7'b1111110;

   typedef enum logic [1:0] {
      STK_PUSH  = 2'b00,
      STK_POP   = 2'b01,
      STK_PEEK  = 2'b10,
      STK_CLEAR = 2'b11
   } stack_op_t;

endpackage

// File: rtl/stack_ram.sv
// Operand stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
   parameter int D_WIDTH = 34,
   parameter int DEPTH   = 16,
   parameter int A_WIDTH = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [A_WIDTH-1:0] waddr_i,
   input  logic [D_WIDTH-1:0] wdata_i,
   input  logic [A_WIDTH-1:0] raddr_i,
   output logic [D_WIDTH-1:0] rdata_o
);

   logic [D_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack: decodes stack instructions, keeps SP and sticky error flags,
// and presents top-of-stack combinationally so writeback can take it in the issue cycle.
module stack_unit
   import proc_pkg::*;
#(
   parameter int D_WIDTH = 34,
   parameter int I_WIDTH = 17,
   parameter int DEPTH   = 16,
   parameter int P_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [I_WIDTH-1:0] instruction_full_i,
   input  logic [D_WIDTH-1:0] rs_i,
   output logic [D_WIDTH-1:0] stack_data_o,
   output logic [P_WIDTH-1:0] count_o,
   output logic               empty_o,
   output logic               full_o,
   output logic               overflow_o,
   output logic               underflow_o
);

   localparam int A_WIDTH = P_WIDTH - 1;

   logic [P_WIDTH-1:0] sp_q, sp_d, sp_m1;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               is_stk, empty, full, ram_we;
   stack_op_t          op;
   logic [D_WIDTH-1:0] ram_rdata;
   logic               unused_instr;

   assign unused_instr = ^instruction_full_i[7:0];

   assign is_stk = valid_i && (instruction_full_i[16:10] == STACK_PREFIX);
   assign op     = stack_op_t'(instruction_full_i[9:8]);
   assign empty  = (sp_q == '0);
   assign full   = (sp_q == P_WIDTH'(DEPTH));
   assign sp_m1  = sp_q - P_WIDTH'(1);

   always_comb begin
      sp_d   = sp_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      ram_we = 1'b0;
      if (is_stk) begin
         case (op)
            STK_PUSH: begin
               if (full) ovf_d = 1'b1;
               else begin
                  ram_we = ~rst;   // reset wins over a same-cycle push
                  sp_d   = sp_q + P_WIDTH'(1);
               end
            end
            STK_POP: begin
               if (empty) unf_d = 1'b1;
               else       sp_d  = sp_m1;
            end
            STK_PEEK: begin
               if (empty) unf_d = 1'b1;
            end
            STK_CLEAR: begin
               sp_d  = '0;
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Index with the low SP bits only; full blocks writes, so sp==DEPTH never addresses storage.
   stack_ram #(
      .D_WIDTH(D_WIDTH),
      .DEPTH  (DEPTH),
      .A_WIDTH(A_WIDTH)
   ) u_ram (
      .clk    (clk),
      .we_i   (ram_we),
      .waddr_i(sp_q[A_WIDTH-1:0]),
      .wdata_i(rs_i),
      .raddr_i(sp_m1[A_WIDTH-1:0]),
      .rdata_o(ram_rdata)
   );

   assign stack_data_o = empty ? '0 : ram_rdata;
   assign count_o      = sp_q;
   assign empty_o      = empty;
   assign full_o       = full;
   assign overflow_o   = ovf_q;
   assign underflow_o  = unf_q;

endmodule
